// File: rtl/comparator_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial comparator controller.
//   state_t : 2-bit controller state; 2'b11 is never entered on purpose and
//             is steered back to idle by the controller.
//   NIBW    : width of the single comparator slice in bits.
package cmp_pkg;

   localparam int NIBW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CMP  = 2'b01,
      S_DONE = 2'b10,
      S_BAD  = 2'b11
   } state_t;

endpackage

// File: rtl/comparator_seq_ctrl_if.sv
// Handshake bundle between producer/consumer and the comparator controller.
//   in_valid/in_ready/a/b        : operand handshake (producer -> controller)
//   out_valid/out_ready          : result handshake (controller -> consumer)
//   gt/lt/eq/nib_count           : result fields, meaningful while out_valid
// master = producer/consumer side, slave = controller side.
interface comparator_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(WIDTH / 4 + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             gt;
   logic             lt;
   logic             eq;
   logic [CW-1:0]    nib_count;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, gt, lt, eq, nib_count
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, gt, lt, eq, nib_count
   );
endinterface

// File: rtl/comparator_seq_ctrl_nibble_cmp_slice.sv
// Purely combinational 4-bit unsigned compare.
//   x, y       : nibbles to compare
//   gt, lt, eq : one-hot relation of x to y
module nibble_cmp_slice
   import cmp_pkg::*;
(
   input  logic [NIBW-1:0] x,
   input  logic [NIBW-1:0] y,
   output logic            gt,
   output logic            lt,
   output logic            eq
);
   always_comb begin
      gt = (x > y);
      lt = (x < y);
      eq = (x == y);
   end
endmodule

// File: rtl/comparator_seq_ctrl.sv
// Nibble-serial unsigned magnitude comparator with valid/ready handshakes.
// Compares one nibble per cycle starting at the MSB nibble and stops at the
// first nibble that differs, so latency is 1..WIDTH/4 cycles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of comparator_seq_ctrl_if (must use the same WIDTH)
module comparator_seq_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   comparator_seq_ctrl_if.slave  bus
);
   localparam int NIB = WIDTH / NIBW;
   localparam int CW  = $clog2(NIB + 1);
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH % NIBW) != 0 || WIDTH < NIBW) begin : g_bad_width
         $error("comparator_seq_ctrl: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IW-1:0]    idx_reg;
   logic [CW-1:0]    count_reg;
   logic             gt_reg;
   logic             lt_reg;
   logic             eq_reg;
   logic [CW-1:0]    nib_count_reg;

   // Nibble views of the captured operands; idx selects which pair the
   // single slice sees this cycle.
   logic [NIBW-1:0] a_nib [NIB];
   logic [NIBW-1:0] b_nib [NIB];

   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_nib
         assign a_nib[gi] = a_reg[gi*NIBW +: NIBW];
         assign b_nib[gi] = b_reg[gi*NIBW +: NIBW];
      end
   endgenerate

   logic s_gt;
   logic s_lt;
   logic s_eq;

   nibble_cmp_slice u_slice (
      .x  (a_nib[idx_reg]),
      .y  (b_nib[idx_reg]),
      .gt (s_gt),
      .lt (s_lt),
      .eq (s_eq)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         idx_reg       <= '0;
         count_reg     <= '0;
         gt_reg        <= 1'b0;
         lt_reg        <= 1'b0;
         eq_reg        <= 1'b0;
         nib_count_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  idx_reg   <= IW'(NIB - 1);
                  count_reg <= '0;
                  state_reg <= S_CMP;
               end
            end
            S_CMP: begin
               count_reg <= count_reg + CW'(1);
               if (s_gt || s_lt) begin
                  gt_reg        <= s_gt;
                  lt_reg        <= s_lt;
                  eq_reg        <= 1'b0;
                  nib_count_reg <= count_reg + CW'(1);
                  state_reg     <= S_DONE;
               end else if (s_eq && idx_reg == '0) begin
                  gt_reg        <= 1'b0;
                  lt_reg        <= 1'b0;
                  eq_reg        <= 1'b1;
                  nib_count_reg <= count_reg + CW'(1);
                  state_reg     <= S_DONE;
               end else begin
                  idx_reg <= idx_reg - IW'(1);
               end
            end
            S_DONE: begin
               // Result flags are left untouched on exit; they only matter
               // while out_valid is high.
               if (bus.out_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == S_IDLE);
   assign bus.out_valid = (state_reg == S_DONE);
   assign bus.gt        = gt_reg;
   assign bus.lt        = lt_reg;
   assign bus.eq        = eq_reg;
   assign bus.nib_count = nib_count_reg;
endmodule

// File: tb/tb_comparator_seq_ctrl.sv
module tb_comparator_seq_ctrl;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic clk;
   logic rst_n;

   comparator_seq_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

   comparator_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  flags;   // {gt, lt, eq}
      int          n;
      int          hold;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: relation from plain arithmetic; nibbles compared = NIB minus
   // the nibble position of the most significant differing bit.
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [2:0] flags, output int n);
      logic [15:0] d;
      bit found;
      d = a ^ b;
      n = NIB;
      found = 0;
      for (int i = 15; i >= 0; i--) begin
         if (d[i] && !found) begin
            n = NIB - i / 4;
            found = 1;
         end
      end
      flags = {a > b, a < b, a == b};
   endfunction

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b);
      check("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
      bus_if.in_valid = 1'b1;
      bus_if.a = a;
      bus_if.b = b;
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      // Operands change after accept; the captured copy must be used.
      bus_if.a = 16'h0000;
      bus_if.b = 16'hFFFF;
   endtask

   task automatic wait_result(input string tag, input logic [2:0] flags, input int n,
                              input int hold, input bit push);
      int c;
      bus_if.out_ready = (hold == 0);
      c = 0;
      while (!bus_if.out_valid && c < 50) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_latency"}, 32'(c), 32'(n));
      check({tag, "_flags"}, 32'({bus_if.gt, bus_if.lt, bus_if.eq}), 32'(flags));
      check({tag, "_nib_count"}, 32'(bus_if.nib_count), 32'(n));
      check({tag, "_in_ready_done"}, 32'(bus_if.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         if (push && i == 0) begin
            bus_if.in_valid = 1'b1;
            bus_if.a = 16'hFFFF;
            bus_if.b = 16'hFFFF;
         end
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
         check({tag, "_hold_flags"}, 32'({bus_if.gt, bus_if.lt, bus_if.eq}), 32'(flags));
         check({tag, "_hold_nib"}, 32'(bus_if.nib_count), 32'(n));
         check({tag, "_hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_out_valid_drop"}, 32'(bus_if.out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
   endtask

   initial begin
      logic [2:0]  mf;
      int          mn;
      logic [15:0] ra;
      logic [15:0] rb;

      vecs[0] = '{16'h0000, 16'h0000, 3'b001, 4, 0};
      vecs[1] = '{16'h8000, 16'h7FFF, 3'b100, 1, 0};
      vecs[2] = '{16'h1234, 16'h1235, 3'b010, 4, 0};
      vecs[3] = '{16'h12F0, 16'h1300, 3'b010, 2, 0};
      vecs[4] = '{16'h4000, 16'h3000, 3'b100, 1, 0};
      vecs[5] = '{16'hFFFF, 16'hFFFE, 3'b100, 4, 2};

      rst_n = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.a = '0;
      bus_if.b = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("rst_flags", 32'({bus_if.gt, bus_if.lt, bus_if.eq}), 32'd0);
      check("rst_nib_count", 32'(bus_if.nib_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b);
         wait_result($sformatf("vec%0d", i), vecs[i].flags, vecs[i].n, vecs[i].hold, 1'b0);
         $display("vec%0d a=%h b=%h gt/lt/eq=%b nib_count=%0d", i, vecs[i].a, vecs[i].b,
                  vecs[i].flags, vecs[i].n);
      end

      // Backpressure with a competing request held during DONE.
      send(16'h00A0, 16'h0090);
      wait_result("bp", 3'b100, 3, 5, 1'b1);
      $display("bp a=00a0 b=0090 held 5 cycles");
      send(16'hFFFF, 16'hFFFF);
      wait_result("bp_next", 3'b001, 4, 0, 1'b0);
      $display("bp_next a=ffff b=ffff");

      // Reset during the second compare cycle.
      send(16'hAAAA, 16'hAAAB);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      check("mid_rst_flags", 32'({bus_if.gt, bus_if.lt, bus_if.eq}), 32'd0);
      check("mid_rst_nib_count", 32'(bus_if.nib_count), 32'd0);
      begin
         int seen;
         seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (bus_if.out_valid) seen++;
         end
         check("mid_rst_no_out_valid", 32'(seen), 32'd0);
      end
      $display("mid_rst a=aaaa b=aaab aborted");

      // Random operands, biased so that many share leading nibbles.
      for (int t = 0; t < 40; t++) begin
         int hold;
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
            2: rb = ra ^ 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         hold = $urandom_range(0, 2);
         model(ra, rb, mf, mn);
         send(ra, rb);
         wait_result($sformatf("rnd%0d", t), mf, mn, hold, 1'b0);
         $display("rnd%0d a=%h b=%h gt/lt/eq=%b nib_count=%0d", t, ra, rb, mf, mn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
